alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// - Upstream control stage for the n-bit ALU. Accepts one operation at a time over a valid/ready command port.
// - Drives the ALU operand, control and flag-in bus, then registers the result and the C/Z flags.
// - Runs shift amounts as repeated 1-bit ALU shifts and keeps a persistent carry for chained ADD/SUB.
// - Returns the result over a valid/ready response port.
// PARAMETERS
// - N  4  operand/result width; must match the ALU's n.
// PORTS
// - clk            in   1  single clock, rising edge.
// - rst            in   1  asynchronous, active-high reset.
// - cmd_valid      in   1  a command is offered.
// - cmd_ready      out  1  the sequencer accepts a command this cycle.
// - cmd_op         in   4  ALU opcode: 0 AND, 1 OR, 2 ADD, 3 INC, 4 DEC, 5 NOT, 6 SUB, 7 XOR, 8 SL, 9 SR.
// - cmd_a, cmd_b   in   N  operands; for SL/SR, cmd_b is the shift count.
// - cmd_flag_in    in   1  ALU flag-in: carry, B-select or fill bit, depending on the op.
// - cmd_use_carry  in   1  replace cmd_flag_in with the stored C flag.
// - alu_a, alu_b   out  N  ALU operands.
// - alu_control    out  4  ALU opcode.
// - alu_flag_in    out  1  ALU flag input.
// - alu_result     in   N  ALU result (combinational).
// - alu_c, alu_z   in   1  ALU flags (combinational).
// - rsp_valid      out  1  a response is held.
// - rsp_ready      in   1  the consumer takes the response.
// - rsp_result     out  N  registered result.
// - rsp_err        out  1  the opcode was illegal (10..15).
// - flag_c, flag_z out  1  persistent flag registers (also driven on the response).
// BEHAVIOUR
// - Reset (async): state IDLE; all registers and outputs 0, including flag_c and flag_z.
//   - cmd_ready=1 on the first cycle after reset release.
//   - Reset during any state aborts the operation; no response is produced.
// - FSM states IDLE, EXEC, SHIFT, RESP. cmd_ready=1 only in IDLE; rsp_valid=1 only in RESP.
// - IDLE, on cmd_valid:
//   - Latch op, a, b and the effective flag-in (use_carry ? flag_c : cmd_flag_in).
//   - op>9 -> RESP with rsp_err=1, rsp_result=0, flags unchanged.
//   - op 8/9 with b==0 -> RESP with rsp_result=a, flag_z=(a==0), flag_c unchanged.
//   - op 8/9 with b!=0 -> SHIFT with work=a, cnt=b.
//   - All other ops -> EXEC.
// - EXEC (1 cycle):
//   - Drive alu_* from the latched values.
//   - At the clock edge: rsp_result<=alu_result, flag_z<=alu_z.
//   - flag_c<=alu_c only for op 2/6; flag_c is kept for all other ops.
//   - Then go to RESP.
// - SHIFT (1 cycle per bit):
//   - Drive alu_a=work, alu_b=1, op 8/9, flag-in = fill bit.
//   - Each edge: work<=alu_result, cnt<=cnt-1.
//   - On the edge where cnt==1: rsp_result<=alu_result, flag_c<=alu_c, flag_z<=alu_z, then go to RESP.
// - RESP:
//   - Hold rsp_* stable until rsp_ready=1, then go to IDLE.
//   - An accept in IDLE cannot coincide with a response.
// - Latency (accept edge to rsp_valid): EXEC ops 1 cycle; shift count c: c cycles; zero-count and illegal ops: 0 extra cycles (RESP follows directly).
// - Outside EXEC/SHIFT, alu_* hold their last values and alu_* inputs are ignored.
// - Widths: cnt is N bits and covers counts up to 2^N-1; no saturation. Fill bits keep shifting in past N.
// STRUCTURE
// - alu_pkg holds: opcode constants ALU_AND..ALU_SR (4'h0..4'h9), the ALUFlagsStruct typedef (C, Z), and the state enum.
// - No sub-module; the ALU is instantiated beside this block, not inside it.
// TESTING (N=4)
// - ADD a=9, b=8, flag_in=0 -> rsp_result=1, C=1, Z=0; rsp_valid 1 cycle after the accept edge.
// - Then ADD a=0, b=0, use_carry=1 -> rsp_result=1, C=0, Z=0.
// - SL a=0011, b=3, fill=0 -> 3 SHIFT cycles; rsp_result=1000, C=1, Z=0.
// - SR a=5, b=0 -> rsp_result=5, Z=0, C unchanged.
// - Op 4'hC -> rsp_err=1, rsp_result=0, flags unchanged.
// - rsp_ready=0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout; rst pulse mid-SHIFT -> rsp_valid=0, cmd_ready=1, flags 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its upstream operation sequencer:
// opcode constants, the flag pair and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_INC = 4'h3;
    localparam logic [3:0] ALU_DEC = 4'h4;
    localparam logic [3:0] ALU_NOT = 4'h5;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_XOR = 4'h7;
    localparam logic [3:0] ALU_SL  = 4'h8;
    localparam logic [3:0] ALU_SR  = 4'h9;

    typedef struct packed {
        logic c;
        logic z;
    } ALUFlagsStruct;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Control stage in front of an N-bit ALU: takes one command at a time, runs
// multi-bit shifts as repeated 1-bit ALU shifts and holds a persistent C/Z pair.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic         cmd_flag_in,
    input  logic         cmd_use_carry,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    output logic         alu_flag_in,
    input  logic [N-1:0] alu_result,
    input  logic         alu_c,
    input  logic         alu_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_err,
    output logic         flag_c,
    output logic         flag_z
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        next_state;
    ALUFlagsStruct flags;
    logic [N-1:0]  cnt;

    logic eff_flag_in;
    logic is_shift;
    logic illegal;
    logic zero_cnt;

    assign eff_flag_in = cmd_use_carry ? flags.c : cmd_flag_in;
    assign is_shift    = (cmd_op == ALU_SL) || (cmd_op == ALU_SR);
    assign illegal     = (cmd_op > ALU_SR);
    assign zero_cnt    = (cmd_b == '0);
    assign flag_c      = flags.c;
    assign flag_z      = flags.z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (illegal || (is_shift && zero_cnt)) begin
                        next_state = RESP;
                    end else if (is_shift) begin
                        next_state = SHIFT;
                    end else begin
                        next_state = EXEC;
                    end
                end
            end
            EXEC: next_state = RESP;
            SHIFT: begin
                if (cnt == ONE) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The alu_* registers double as the latched command: alu_a is also the
    // shift work register, so they only change when an ALU pass is started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            alu_flag_in <= 1'b0;
            cnt         <= '0;
            rsp_result  <= '0;
            rsp_err     <= 1'b0;
            flags       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_err <= illegal;
                        if (illegal) begin
                            rsp_result <= '0;
                        end else if (is_shift && zero_cnt) begin
                            rsp_result <= cmd_a;
                            flags.z    <= (cmd_a == '0);
                        end else begin
                            alu_a       <= cmd_a;
                            alu_b       <= is_shift ? ONE : cmd_b;
                            alu_control <= cmd_op;
                            alu_flag_in <= eff_flag_in;
                            cnt         <= cmd_b;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    flags.z    <= alu_z;
                    if ((alu_control == ALU_ADD) || (alu_control == ALU_SUB)) begin
                        flags.c <= alu_c;
                    end
                end
                SHIFT: begin
                    alu_a <= alu_result;
                    cnt   <= cnt - ONE;
                    if (cnt == ONE) begin
                        rsp_result <= alu_result;
                        flags.c    <= alu_c;
                        flags.z    <= alu_z;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU beside it.
module tb_alu_op_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic [N-1:0] cmd_a = '0;
    logic [N-1:0] cmd_b = '0;
    logic         cmd_flag_in = 1'b0;
    logic         cmd_use_carry = 1'b0;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic         alu_flag_in;
    logic [N-1:0] alu_result;
    logic         alu_c;
    logic         alu_z;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic         rsp_err;
    logic         flag_c;
    logic         flag_z;

    int checks = 0;
    int failures = 0;
    int lat;

    alu_op_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flag_in(cmd_flag_in), .cmd_use_carry(cmd_use_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_flag_in(alu_flag_in),
        .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .flag_c(flag_c), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    // Reference ALU; shifts move one bit per pass with flag_in as the fill bit.
    always_comb begin
        logic [N:0] sum;
        sum        = '0;
        alu_result = '0;
        alu_c      = 1'b0;
        case (alu_control)
            4'h0: alu_result = alu_a & alu_b;
            4'h1: alu_result = alu_a | alu_b;
            4'h2: begin sum = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_flag_in}; {alu_c, alu_result} = sum; end
            4'h3: begin sum = {1'b0, alu_a} + 1; {alu_c, alu_result} = sum; end
            4'h4: begin alu_result = alu_a - 1'b1; alu_c = (alu_a == '0); end
            4'h5: alu_result = ~alu_a;
            4'h6: begin sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, alu_flag_in}; {alu_c, alu_result} = sum; end
            4'h7: alu_result = alu_a ^ alu_b;
            4'h8: begin alu_result = {alu_a[N-2:0], alu_flag_in}; alu_c = alu_a[N-1]; end
            4'h9: begin alu_result = {alu_flag_in, alu_a[N-1:1]}; alu_c = alu_a[0]; end
            default: ;
        endcase
        alu_z = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a command from a falling edge and count rising edges from the
    // accept edge until rsp_valid is seen; returns -1 if it never shows.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic fin, input logic uc, output int latency);
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_flag_in = fin; cmd_use_carry = uc;
        cmd_valid = 1'b1;
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        latency = 0;
        while (!rsp_valid && latency < 40) begin
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
        if (!rsp_valid) latency = -1;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);
        check("rsp_valid_after_release", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [N-1:0] held;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_flags", 32'({flag_c, flag_z}), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);

        // ADD 9+8: 17 -> result 1, carry out
        issue(4'h2, 4'd9, 4'd8, 1'b0, 1'b0, lat);
        check("add_latency", 32'(lat), 32'd1);
        check("add_result", 32'(rsp_result), 32'd1);
        check("add_flags_cz", 32'({flag_c, flag_z}), 32'b10);
        check("add_err", 32'(rsp_err), 32'd0);
        release_rsp();

        // Chained ADD 0+0+C
        issue(4'h2, 4'd0, 4'd0, 1'b0, 1'b1, lat);
        check("addc_result", 32'(rsp_result), 32'd1);
        check("addc_flags_cz", 32'({flag_c, flag_z}), 32'b00);
        release_rsp();

        // SL 0011 by 3 -> 1000, last bit out is 1
        issue(4'h8, 4'b0011, 4'd3, 1'b0, 1'b0, lat);
        check("sl_latency", 32'(lat), 32'd3);
        check("sl_result", 32'(rsp_result), 32'b1000);
        check("sl_flags_cz", 32'({flag_c, flag_z}), 32'b10);
        release_rsp();

        // SR by zero: pass-through, C kept at 1
        issue(4'h9, 4'd5, 4'd0, 1'b0, 1'b0, lat);
        check("sr0_latency", 32'(lat), 32'd0);
        check("sr0_result", 32'(rsp_result), 32'd5);
        check("sr0_flags_cz", 32'({flag_c, flag_z}), 32'b10);
        release_rsp();

        // Illegal opcode
        issue(4'hC, 4'd7, 4'd3, 1'b0, 1'b0, lat);
        check("ill_latency", 32'(lat), 32'd0);
        check("ill_err", 32'(rsp_err), 32'd1);
        check("ill_result", 32'(rsp_result), 32'd0);
        check("ill_flags_cz", 32'({flag_c, flag_z}), 32'b10);
        release_rsp();

        // XOR to zero: Z set, C untouched
        issue(4'h7, 4'd5, 4'd5, 1'b0, 1'b0, lat);
        check("xor_err", 32'(rsp_err), 32'd0);
        check("xor_result", 32'(rsp_result), 32'd0);
        check("xor_flags_cz", 32'({flag_c, flag_z}), 32'b11);
        release_rsp();

        // SUB 3-5 with carry-in 1: 3+1010+1 = 1110, no carry out
        issue(4'h6, 4'd3, 4'd5, 1'b1, 1'b0, lat);
        check("sub_result", 32'(rsp_result), 32'b1110);
        check("sub_flags_cz", 32'({flag_c, flag_z}), 32'b00);
        release_rsp();

        // SR 1000 by 5 with fill 1: fill keeps shifting past N
        issue(4'h9, 4'b1000, 4'd5, 1'b1, 1'b0, lat);
        check("sr5_latency", 32'(lat), 32'd5);
        check("sr5_result", 32'(rsp_result), 32'b1111);
        check("sr5_flags_cz", 32'({flag_c, flag_z}), 32'b10);
        release_rsp();

        // Backpressure: AND 1100 & 1010 = 1000 held for 5 cycles
        issue(4'h0, 4'b1100, 4'b1010, 1'b0, 1'b0, lat);
        held = rsp_result;
        check("and_result", 32'(rsp_result), 32'b1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_rsp_result", 32'(rsp_result), 32'(held));
        end
        release_rsp();

        // Reset in the middle of a long shift
        @(negedge clk);
        cmd_op = 4'h8; cmd_a = 4'd1; cmd_b = 4'd10; cmd_flag_in = 1'b0; cmd_use_carry = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("shift_busy_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_flags", 32'({flag_c, flag_z}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
